// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the serial USB CRC5/CRC16 generator/checker.
// Width-dependent parameter defaults are resolved through the helper functions.
package usb_crc_pkg;

  typedef enum logic {
    GEN = 1'b0,
    CHK = 1'b1
  } crc_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StAppend
  } state_t;

  localparam logic [4:0]  CRC5_POLY  = 5'b00101;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [4:0]  CRC5_RES   = 5'b01100;
  localparam logic [15:0] CRC16_RES  = 16'h800D;

  function automatic logic [15:0] default_poly(input int unsigned w);
    return (w == 16) ? CRC16_POLY : {11'd0, CRC5_POLY};
  endfunction

  function automatic logic [15:0] default_res(input int unsigned w);
    return (w == 16) ? CRC16_RES : {11'd0, CRC5_RES};
  endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// Remainder register: all-ones seed load, one data step per accepted bit, and
// zero-fill shift used while the complemented remainder is streamed out.
module usb_crc_lfsr #(
  parameter int unsigned     CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [CRC_W-1:0] crc_o,
  output logic [CRC_W-1:0] next_o
);

  logic [CRC_W-1:0] crc_q, crc_d, base;
  logic             fb;

  // A step in the same cycle as a load starts from the seed, not the old value.
  always_comb begin
    base   = load_i ? '1 : crc_q;
    fb     = base[CRC_W-1] ^ din_i;
    next_o = {base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    crc_d  = crc_q;
    if (step_i) begin
      crc_d = next_o;
    end else if (shift_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0};
    end else if (load_i) begin
      crc_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_crc_serial.sv
// Bit-serial USB CRC block: generate mode appends the complemented remainder,
// check mode compares the final remainder against the good-packet residue.
module usb_crc_serial
  import usb_crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(default_poly(CRC_W)),
  parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(default_res(CRC_W))
) (
  input  logic clk,
  input  logic rst_b,
  input  logic ce,
  input  logic start,
  input  logic mode,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  output logic busy,
  output logic crc_ok,
  output logic crc_err
);

  localparam int unsigned CntW = $clog2(CRC_W);

  if (CRC_W != 5 && CRC_W != 16) begin : gen_bad_width
    $error("usb_crc_serial: CRC_W must be 5 or 16");
  end

  state_t           state_q;
  crc_mode_t        mode_q, acc_mode;
  logic [CntW-1:0]  cnt_q;
  logic             out_valid_q, out_bit_q, out_last_q, crc_ok_q, crc_err_q;
  logic             accept, lfsr_load, lfsr_step, lfsr_shift;
  logic [CRC_W-1:0] crc, crc_next;

  always_comb begin
    accept     = ce & in_valid & (start | (state_q == StData));
    acc_mode   = start ? crc_mode_t'(mode) : mode_q;
    lfsr_load  = ce & start;
    lfsr_step  = accept;
    lfsr_shift = ce & ~start & (state_q == StAppend);
  end

  usb_crc_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_lfsr (
    .clk     (clk),
    .rst_b   (rst_b),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .shift_i (lfsr_shift),
    .din_i   (in_bit),
    .crc_o   (crc),
    .next_o  (crc_next)
  );

  // Later assignments deliberately override earlier ones within a bit-time.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      mode_q      <= GEN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
    end else if (ce) begin
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      if (start) begin
        state_q <= StData;
        mode_q  <= crc_mode_t'(mode);
        cnt_q   <= '0;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= in_bit;
        if (in_last) begin
          if (acc_mode == GEN) begin
            state_q <= StAppend;
            cnt_q   <= '0;
          end else begin
            state_q   <= StIdle;
            crc_ok_q  <= (crc_next == RESIDUE);
            crc_err_q <= (crc_next != RESIDUE);
          end
        end
      end else if (!start && state_q == StAppend) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= ~crc[CRC_W-1];
        cnt_q       <= cnt_q + 1'b1;
        if (cnt_q == CntW'(CRC_W - 1)) begin
          out_last_q <= 1'b1;
          state_q    <= StIdle;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_usb_crc_serial.sv
// Directed and loopback bench for usb_crc_serial at CRC_W=5 and CRC_W=16.
module tb_usb_crc_serial;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic ce, start, mode, in_valid, in_bit, in_last, sel;
  logic ce5, ce16;
  logic ov5, ob5, ol5, bz5, ok5, er5;
  logic ov16, ob16, ol16, bz16, ok16, er16;
  logic ov, ob, ol, bz, ok, er;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] obv;
  int          ocnt, last_idx, ok_n, err_n, hold_err;
  int          duty = 1;

  always #5 clk = ~clk;

  assign ce5  = ce & ~sel;
  assign ce16 = ce & sel;
  assign ov = sel ? ov16 : ov5;
  assign ob = sel ? ob16 : ob5;
  assign ol = sel ? ol16 : ol5;
  assign bz = sel ? bz16 : bz5;
  assign ok = sel ? ok16 : ok5;
  assign er = sel ? er16 : er5;

  usb_crc_serial #(.CRC_W(5)) dut5 (
    .clk(clk), .rst_b(rst_b), .ce(ce5), .start(start), .mode(mode), .in_valid(in_valid),
    .in_bit(in_bit), .in_last(in_last), .out_valid(ov5), .out_bit(ob5), .out_last(ol5),
    .busy(bz5), .crc_ok(ok5), .crc_err(er5)
  );

  usb_crc_serial #(.CRC_W(16)) dut16 (
    .clk(clk), .rst_b(rst_b), .ce(ce16), .start(start), .mode(mode), .in_valid(in_valid),
    .in_bit(in_bit), .in_last(in_last), .out_valid(ov16), .out_bit(ob16), .out_last(ol16),
    .busy(bz16), .crc_ok(ok16), .crc_err(er16)
  );

  // Reference remainder after n data bits, LSB-first, from the all-ones seed.
  function automatic logic [15:0] crc_model(input int w, input int n, input logic [63:0] data);
    logic [15:0] r, p, mask;
    logic        fb;
    p    = (w == 16) ? 16'h8005 : 16'h0005;
    mask = (w == 16) ? 16'hFFFF : 16'h001F;
    r    = mask;
    for (int i = 0; i < n; i++) begin
      fb = r[w-1] ^ data[i];
      r  = (r << 1) & mask;
      if (fb) r = r ^ p;
    end
    return r;
  endfunction

  task automatic exp_stream(input int w, input int n, input logic [63:0] data,
                            output logic [63:0] ev, output int en);
    logic [15:0] r;
    r  = crc_model(w, n, data);
    ev = '0;
    for (int i = 0; i < n; i++) ev[i] = data[i];
    for (int k = 0; k < w; k++) ev[n+k] = ~r[w-1-k];
    en = n + w;
  endtask

  task automatic clear_obs;
    obv = '0; ocnt = 0; last_idx = 0; ok_n = 0; err_n = 0;
  endtask

  // One bit-time: duty-1 idle clocks with random noise, then one ce clock.
  task automatic tick_ce(input logic s, input logic iv, input logic ib, input logic il);
    logic [5:0] snap;
    snap = {ov, ob, ol, ok, er, bz};
    for (int k = 1; k < duty; k++) begin
      ce = 1'b0; start = 1'($urandom); in_valid = 1'($urandom);
      in_bit = 1'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
      if ({ov, ob, ol, ok, er, bz} !== snap) hold_err++;
    end
    ce = 1'b1; start = s; in_valid = iv; in_bit = ib; in_last = il;
    @(posedge clk); #1;
    ce = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    if (ov === 1'b1 && ocnt < 64) begin
      obv[ocnt] = ob;
      ocnt++;
      if (ol === 1'b1) last_idx = ocnt;
    end
    if (ok === 1'b1) ok_n++;
    if (er === 1'b1) err_n++;
  endtask

  task automatic send(input logic m, input int n, input logic [63:0] data);
    clear_obs();
    mode = m;
    for (int i = 0; i < n; i++) tick_ce(i == 0, 1'b1, data[i], i == n - 1);
    for (int k = 0; k < 24 && bz === 1'b1; k++) tick_ce(1'b0, 1'b0, 1'b0, 1'b0);
    tick_ce(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ov5, ob5, ol5, ok5, er5, bz5} !== 6'b0)
      $display("FAIL reset_outs5: got %b, expected 000000", {ov5, ob5, ol5, ok5, er5, bz5});
    else n_pass++;
    n_checks++;
    if ({ov16, ob16, ol16, ok16, er16, bz16} !== 6'b0)
      $display("FAIL reset_outs16: got %b, expected 000000", {ov16, ob16, ol16, ok16, er16, bz16});
    else n_pass++;
    rst_b = 1'b1;
    sel = 1'b0;
    clear_obs();
    for (int i = 0; i < 6; i++) tick_ce(1'b0, 1'b1, 1'(i & 1), i == 5);
    n_checks++;
    if (ocnt != 0 || ok_n != 0 || err_n != 0 || bz !== 1'b0)
      $display("FAIL no_start_no_output: got bits=%0d ok=%0d err=%0d busy=%b, expected 0 0 0 0",
               ocnt, ok_n, err_n, bz);
    else n_pass++;
  endtask

  task automatic test_gen_vectors;
    sel = 1'b0;
    send(1'b0, 1, 64'h0);
    n_checks++;
    if (ocnt != 6 || obv !== 64'h8)
      $display("FAIL gen5_onebit: got %0d bits %h, expected 6 bits 8", ocnt, obv);
    else n_pass++;
    n_checks++;
    if (last_idx != 6) $display("FAIL gen5_last: got %0d, expected 6", last_idx);
    else n_pass++;
    sel = 1'b1;
    send(1'b0, 1, 64'h0);
    n_checks++;
    if (ocnt != 17 || obv !== 64'h4002)
      $display("FAIL gen16_onebit: got %0d bits %h, expected 17 bits 4002", ocnt, obv);
    else n_pass++;
    n_checks++;
    if (last_idx != 17 || bz !== 1'b0)
      $display("FAIL gen16_last: got last=%0d busy=%b, expected 17 0", last_idx, bz);
    else n_pass++;
  endtask

  task automatic test_check_vectors;
    logic exp_ok;
    sel = 1'b0;
    send(1'b1, 6, 64'h8);
    n_checks++;
    if (ok_n != 1 || err_n != 0 || ocnt != 6)
      $display("FAIL chk5_good: got ok=%0d err=%0d bits=%0d, expected 1 0 6", ok_n, err_n, ocnt);
    else n_pass++;
    send(1'b1, 6, 64'h0);
    n_checks++;
    if (ok_n != 0 || err_n != 1)
      $display("FAIL chk5_bad: got ok=%0d err=%0d, expected 0 1", ok_n, err_n);
    else n_pass++;
    sel = 1'b1;
    exp_ok = (crc_model(16, 16, 64'h0) == 16'h800D);
    send(1'b1, 16, 64'h0);
    n_checks++;
    if (ok_n != int'(exp_ok) || err_n != int'(!exp_ok))
      $display("FAIL chk16_zero: got ok=%0d err=%0d, expected %0d %0d",
               ok_n, err_n, exp_ok, !exp_ok);
    else n_pass++;
  endtask

  task automatic test_loopback(input int w);
    logic [63:0] data, ev, lb;
    int          n, en, ln, idx;
    sel = (w == 16);
    for (int p = 0; p < 200; p++) begin
      n    = $urandom_range(1, 16);
      data = {$urandom, $urandom} & ((64'd1 << n) - 64'd1);
      send(1'b0, n, data);
      exp_stream(w, n, data, ev, en);
      n_checks++;
      if (ocnt != en || obv !== ev || last_idx != en)
        $display("FAIL loop%0d_gen: pkt %0d got %0d bits %h last %0d, expected %0d bits %h",
                 w, p, ocnt, obv, last_idx, en, ev);
      else n_pass++;
      lb = obv;
      ln = ocnt;
      send(1'b1, ln, lb);
      n_checks++;
      if (ok_n != 1 || err_n != 0)
        $display("FAIL loop%0d_chk: pkt %0d got ok=%0d err=%0d, expected 1 0", w, p, ok_n, err_n);
      else n_pass++;
      idx = $urandom_range(0, ln - 1);
      lb[idx] = ~lb[idx];
      send(1'b1, ln, lb);
      n_checks++;
      if (ok_n != 0 || err_n != 1)
        $display("FAIL loop%0d_flip: pkt %0d bit %0d got ok=%0d err=%0d, expected 0 1",
                 w, p, idx, ok_n, err_n);
      else n_pass++;
    end
  endtask

  task automatic test_duty;
    logic [63:0] ev;
    int          en;
    sel = 1'b0;
    duty = 4;
    hold_err = 0;
    send(1'b0, 8, 64'hA5);
    exp_stream(5, 8, 64'hA5, ev, en);
    n_checks++;
    if (ocnt != en || obv !== ev || last_idx != en)
      $display("FAIL duty_stream: got %0d bits %h, expected %0d bits %h", ocnt, obv, en, ev);
    else n_pass++;
    clear_obs();
    for (int i = 0; i < 10; i++) tick_ce(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    n_checks++;
    if (ocnt != 0 || ok_n != 0 || err_n != 0 || bz !== 1'b0)
      $display("FAIL duty_idle_quiet: got bits=%0d ok=%0d err=%0d busy=%b, expected 0 0 0 0",
               ocnt, ok_n, err_n, bz);
    else n_pass++;
    n_checks++;
    if (hold_err != 0) $display("FAIL duty_hold: got %0d changes while ce=0, expected 0", hold_err);
    else n_pass++;
    duty = 1;
  endtask

  task automatic test_reset_mid_append;
    logic [63:0] ev;
    int          en;
    sel = 1'b1;
    mode = 1'b0;
    clear_obs();
    for (int i = 0; i < 4; i++) tick_ce(i == 0, 1'b1, 1'(4'b1011 >> i), i == 3);
    for (int i = 0; i < 5; i++) tick_ce(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if ({ov16, ob16, ol16, ok16, er16, bz16} !== 6'b0)
      $display("FAIL async_reset16: got %b, expected 000000", {ov16, ob16, ol16, ok16, er16, bz16});
    else n_pass++;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 4, 64'hB);
    exp_stream(16, 4, 64'hB, ev, en);
    n_checks++;
    if (ocnt != en || obv !== ev || last_idx != en)
      $display("FAIL after_reset_crc: got %0d bits %h, expected %0d bits %h", ocnt, obv, en, ev);
    else n_pass++;
  endtask

  task automatic test_abort;
    logic [63:0] ev;
    int          en;
    sel = 1'b0;
    mode = 1'b0;
    clear_obs();
    tick_ce(1'b1, 1'b1, 1'b1, 1'b0);
    tick_ce(1'b0, 1'b1, 1'b0, 1'b0);
    tick_ce(1'b0, 1'b1, 1'b1, 1'b1);
    tick_ce(1'b0, 1'b0, 1'b0, 1'b0);
    tick_ce(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (last_idx != 0 || bz !== 1'b1)
      $display("FAIL abort_pre: got last=%0d busy=%b, expected 0 1", last_idx, bz);
    else n_pass++;
    send(1'b0, 5, 64'h0D);
    exp_stream(5, 5, 64'h0D, ev, en);
    n_checks++;
    if (ocnt != en || obv !== ev || last_idx != en)
      $display("FAIL abort_restart: got %0d bits %h last %0d, expected %0d bits %h last %0d",
               ocnt, obv, last_idx, en, ev, en);
    else n_pass++;
  endtask

  initial begin
    ce = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    sel = 1'b0;
    test_reset();
    test_gen_vectors();
    test_check_vectors();
    test_loopback(5);
    test_loopback(16);
    test_duty();
    test_reset_mid_append();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
